// File: rtl/rv_timer_dev.sv
// RISC-V machine timer peripheral: 64-bit MTIME/MTIMECMP with prescaled tick,
// single-cycle bus device response and a registered timer interrupt level.
module rv_timer_dev #(
    parameter int unsigned PrescaleWidth = 16,
    parameter int unsigned ResetPrescale = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dev_req_i,
    input  logic        dev_we_i,
    input  logic [3:0]  dev_be_i,
    input  logic [31:0] dev_addr_i,
    input  logic [31:0] dev_wdata_i,
    output logic        dev_rvalid_o,
    output logic [31:0] dev_rdata_o,
    output logic        dev_err_o,
    output logic        timer_irq_o
);

    localparam logic [7:0] IDX_MTIME_LO    = 8'd0;
    localparam logic [7:0] IDX_MTIME_HI    = 8'd1;
    localparam logic [7:0] IDX_MTIMECMP_LO = 8'd2;
    localparam logic [7:0] IDX_MTIMECMP_HI = 8'd3;
    localparam logic [7:0] IDX_CTRL        = 8'd4;
    localparam logic [7:0] IDX_PRESCALE    = 8'd5;

    logic [63:0]              mtime_q, mtime_d;
    logic [63:0]              mtimecmp_q, mtimecmp_d;
    logic                     en_q, en_d;
    logic [PrescaleWidth-1:0] prescale_q, prescale_d;
    logic [PrescaleWidth-1:0] pc_q, pc_d;
    logic                     irq_d;

    logic [7:0]  reg_idx;
    logic        mapped;
    logic        wr;
    logic        tick;
    logic [31:0] wmask;
    logic [31:0] rd_val;
    logic        unused_addr;

    assign reg_idx     = dev_addr_i[9:2];
    assign mapped      = (reg_idx <= IDX_PRESCALE);
    assign wr          = dev_req_i & dev_we_i & mapped;
    assign tick        = en_q & (pc_q == prescale_q);
    assign wmask       = {{8{dev_be_i[3]}}, {8{dev_be_i[2]}}, {8{dev_be_i[1]}}, {8{dev_be_i[0]}}};
    assign unused_addr = ^{dev_addr_i[31:10], dev_addr_i[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                          input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    always_comb begin
        // NOTE: default first so every path assigns rd_val and no latch is inferred.
        rd_val = '0;
        case (reg_idx)
            IDX_MTIME_LO:    rd_val = mtime_q[31:0];
            IDX_MTIME_HI:    rd_val = mtime_q[63:32];
            IDX_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
            IDX_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
            IDX_CTRL:        rd_val = {31'b0, en_q};
            IDX_PRESCALE:    rd_val = 32'(prescale_q);
            default:         rd_val = '0;
        endcase
    end

    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        prescale_d = prescale_q;
        pc_d       = pc_q;

        // A write to either MTIME half wins over the tick; the tick is lost.
        if (wr && reg_idx == IDX_MTIME_LO) begin
            mtime_d[31:0] = merge(mtime_q[31:0], dev_wdata_i, wmask);
        end else if (wr && reg_idx == IDX_MTIME_HI) begin
            mtime_d[63:32] = merge(mtime_q[63:32], dev_wdata_i, wmask);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        if (wr && reg_idx == IDX_MTIMECMP_LO) mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], dev_wdata_i, wmask);
        if (wr && reg_idx == IDX_MTIMECMP_HI) mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], dev_wdata_i, wmask);
        if (wr && reg_idx == IDX_CTRL)        en_d = wmask[0] ? dev_wdata_i[0] : en_q;
        if (wr && reg_idx == IDX_PRESCALE) begin
            prescale_d = (prescale_q & ~wmask[PrescaleWidth-1:0])
                       | (dev_wdata_i[PrescaleWidth-1:0] & wmask[PrescaleWidth-1:0]);
        end

        if (wr && (reg_idx == IDX_CTRL || reg_idx == IDX_PRESCALE)) begin
            pc_d = '0;
        end else if (en_q) begin
            pc_d = tick ? '0 : pc_q + 1'b1;
        end

        irq_d = en_d & (mtime_d >= mtimecmp_d);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q      <= '0;
            mtimecmp_q   <= '1;
            en_q         <= 1'b0;
            prescale_q   <= PrescaleWidth'(ResetPrescale);
            pc_q         <= '0;
            timer_irq_o  <= 1'b0;
            dev_rvalid_o <= 1'b0;
            dev_rdata_o  <= '0;
            dev_err_o    <= 1'b0;
        end else begin
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            en_q         <= en_d;
            prescale_q   <= prescale_d;
            pc_q         <= pc_d;
            timer_irq_o  <= irq_d;
            dev_rvalid_o <= dev_req_i;
            dev_rdata_o  <= (dev_req_i && !dev_we_i) ? rd_val : '0;
            dev_err_o    <= dev_req_i & ~mapped;
        end
    end

endmodule

// File: tb/tb_rv_timer_dev.sv
// Randomised scoreboard bench for rv_timer_dev: a driver pushes expected bus
// responses from a reference model, a monitor pops and compares them.
module tb_rv_timer_dev;

    localparam logic [31:0] PS_MASK = 32'h0000_FFFF;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        dev_req_i = 1'b0;
    logic        dev_we_i = 1'b0;
    logic [3:0]  dev_be_i = 4'h0;
    logic [31:0] dev_addr_i = '0;
    logic [31:0] dev_wdata_i = '0;
    logic        dev_rvalid_o;
    logic [31:0] dev_rdata_o;
    logic        dev_err_o;
    logic        timer_irq_o;

    rv_timer_dev #(.PrescaleWidth(16), .ResetPrescale(0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .dev_req_i(dev_req_i), .dev_we_i(dev_we_i), .dev_be_i(dev_be_i),
        .dev_addr_i(dev_addr_i), .dev_wdata_i(dev_wdata_i),
        .dev_rvalid_o(dev_rvalid_o), .dev_rdata_o(dev_rdata_o),
        .dev_err_o(dev_err_o), .timer_irq_o(timer_irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    // Reference state: the timer as software sees it.
    logic [63:0] m_mtime, m_cmp;
    bit          m_en, m_irq;
    logic [31:0] m_ps, m_pc;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [9:0] off);
        case (off)
            10'h00:  return m_mtime[31:0];
            10'h04:  return m_mtime[63:32];
            10'h08:  return m_cmp[31:0];
            10'h0C:  return m_cmp[63:32];
            10'h10:  return {31'b0, m_en};
            10'h14:  return m_ps;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_mtime = '0;
        m_cmp   = '1;
        m_en    = 1'b0;
        m_irq   = 1'b0;
        m_ps    = 32'h0;
        m_pc    = 32'h0;
    endtask

    // One bus cycle: check the irq level, drive inputs, predict and advance the model.
    task automatic cycle(input bit req, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        logic [9:0]  off;
        bit          mapped, wr, tick;
        logic [63:0] n_mtime, n_cmp;
        bit          n_en;
        logic [31:0] n_ps, n_pc;
        @(negedge clk_i);
        check("irq_level", {63'b0, timer_irq_o}, {63'b0, m_irq});
        dev_req_i   = req;
        dev_we_i    = we;
        dev_be_i    = be;
        dev_addr_i  = addr;
        dev_wdata_i = wdata;
        off    = addr[9:0] & 10'h3FC;
        mapped = (off < 10'h18);
        if (req) begin
            e.due   = cyc + 1;
            e.err   = !mapped;
            e.rdata = (!we && mapped) ? m_read(off) : 32'h0;
            q.push_back(e);
        end
        wr   = req && we && mapped;
        tick = m_en && (m_pc == m_ps);
        n_mtime = m_mtime;
        n_cmp   = m_cmp;
        n_en    = m_en;
        n_ps    = m_ps;
        n_pc    = m_pc;
        if (wr && off == 10'h00)      n_mtime[31:0]  = merge(m_mtime[31:0], wdata, be);
        else if (wr && off == 10'h04) n_mtime[63:32] = merge(m_mtime[63:32], wdata, be);
        else if (tick)                n_mtime = m_mtime + 64'd1;
        if (wr && off == 10'h08) n_cmp[31:0]  = merge(m_cmp[31:0], wdata, be);
        if (wr && off == 10'h0C) n_cmp[63:32] = merge(m_cmp[63:32], wdata, be);
        if (wr && off == 10'h10 && be[0]) n_en = wdata[0];
        if (wr && off == 10'h14) n_ps = merge(m_ps, wdata, be) & PS_MASK;
        if (wr && (off == 10'h10 || off == 10'h14)) n_pc = 0;
        else if (m_en) n_pc = tick ? 0 : m_pc + 1;
        m_mtime = n_mtime;
        m_cmp   = n_cmp;
        m_en    = n_en;
        m_ps    = n_ps;
        m_pc    = n_pc;
        m_irq   = n_en && (n_mtime >= n_cmp);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic wr_reg(input logic [31:0] addr, input logic [31:0] data);
        cycle(1'b1, 1'b1, 4'hF, addr, data);
    endtask

    task automatic rd_reg(input logic [31:0] addr);
        cycle(1'b1, 1'b0, 4'h0, addr, 32'h0);
    endtask

    // Monitor: every response must match the oldest expectation, exactly on its due cycle.
    always @(posedge clk_i) begin
        exp_t e;
        cyc++;
        #1;
        if (dev_rvalid_o) begin
            if (q.size() == 0) begin
                check("unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                check("resp_latency", 64'(cyc), 64'(e.due));
                check("resp_rdata", {32'b0, dev_rdata_o}, {32'b0, e.rdata});
                check("resp_err", {63'b0, dev_err_o}, {63'b0, e.err});
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            check("missing_rvalid", 64'd0, 64'd1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        repeat (3) @(posedge clk_i);
        #2;
        check("rst_rvalid", {63'b0, dev_rvalid_o}, 64'd0);
        check("rst_rdata", {32'b0, dev_rdata_o}, 64'd0);
        check("rst_err", {63'b0, dev_err_o}, 64'd0);
        check("rst_irq", {63'b0, timer_irq_o}, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Reset values, including MTIMECMP all-ones.
        rd_reg(32'h08);
        rd_reg(32'h0C);
        rd_reg(32'h00);
        rd_reg(32'h10);
        rd_reg(32'h14);

        // Prescale of 3: one tick every 4th cycle.
        wr_reg(32'h14, 32'd3);
        wr_reg(32'h10, 32'd1);
        idle(40);
        rd_reg(32'h00);
        rd_reg(32'h04);

        // 64-bit wrap to zero.
        wr_reg(32'h10, 32'd0);
        wr_reg(32'h00, 32'hFFFF_FFFE);
        wr_reg(32'h04, 32'hFFFF_FFFF);
        wr_reg(32'h14, 32'd0);
        wr_reg(32'h10, 32'd1);
        idle(1);
        rd_reg(32'h00);
        rd_reg(32'h04);
        rd_reg(32'h00);

        // Compare interrupt at MTIME == 20, then cleared by raising MTIMECMP_HI.
        wr_reg(32'h10, 32'd0);
        wr_reg(32'h00, 32'd0);
        wr_reg(32'h04, 32'd0);
        wr_reg(32'h08, 32'd20);
        wr_reg(32'h0C, 32'd0);
        wr_reg(32'h10, 32'd1);
        idle(25);
        wr_reg(32'h0C, 32'd1);
        idle(3);
        rd_reg(32'h0C);

        // Unmapped offsets and a byte-masked CTRL write.
        wr_reg(32'h10, 32'd0);
        rd_reg(32'h18);
        wr_reg(32'h3FC, 32'hDEAD_BEEF);
        cycle(1'b1, 1'b1, 4'b0010, 32'h10, 32'h12);
        rd_reg(32'h10);
        rd_reg(32'h08);

        // MTIME_LO write colliding with a tick.
        wr_reg(32'h14, 32'd0);
        wr_reg(32'h10, 32'd1);
        idle(2);
        wr_reg(32'h00, 32'h100);
        rd_reg(32'h00);
        rd_reg(32'h04);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            int          k;
            logic [31:0] a, d;
            k = int'($urandom_range(0, 7));
            a = (k < 6) ? 32'(k * 4) : (k == 6) ? 32'h18 : $urandom;
            d = $urandom;
            if (a[9:0] == 10'h14) d = $urandom_range(0, 3);
            if (a[9:0] == 10'h10 && $urandom_range(0, 3) != 0) d = 32'd1;
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), a, d);
        end

        // Reset asserted while a read is in flight: it must never be answered.
        idle(3);
        @(negedge clk_i);
        dev_req_i  = 1'b1;
        dev_we_i   = 1'b0;
        dev_addr_i = 32'h0;
        #2;
        rst_ni = 1'b0;
        m_reset();
        #1;
        dev_req_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i);
            #2;
            check("no_rvalid_after_reset", {63'b0, dev_rvalid_o}, 64'd0);
        end
        rd_reg(32'h0C);
        rd_reg(32'h10);

        idle(3);
        check("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_timer_dev.md
RV_TIMER_DEV -- requirements
Module: rv_timer_dev

Interface
REQ-001 SHALL have parameter PrescaleWidth, default 16, width of the tick prescaler.
REQ-002 SHALL have parameter ResetPrescale, default 0, reset value of PRESCALE (0 = increment every cycle).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port dev_req_i  input  1  bus device request; always accepted, no grant.
REQ-006 SHALL have port dev_we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have port dev_be_i  input  4  byte enables for writes.
REQ-008 SHALL have port dev_addr_i  input  32  byte address; only bits [9:2] decoded (1 kB window).
REQ-009 SHALL have port dev_wdata_i  input  32  write data.
REQ-010 SHALL have port dev_rvalid_o  output  1  response valid, reads and writes.
REQ-011 SHALL have port dev_rdata_o  output  32  read data, valid with dev_rvalid_o.
REQ-012 SHALL have port dev_err_o  output  1  error response, valid with dev_rvalid_o.
REQ-013 SHALL have port timer_irq_o  output  1  machine timer interrupt level, drives core irq_timer_i.

Function
REQ-014 SHALL implement the register map by offset dev_addr_i[9:0]: 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL (bit0 EN, bits[31:1] read 0), 0x14 PRESCALE (low PrescaleWidth bits, upper read 0).
REQ-015 SHALL respond to every request exactly one cycle later: dev_rvalid_o = 1 for one cycle; back-to-back requests on consecutive cycles each get their own response.
REQ-016 SHALL, on access to an unmapped offset, assert dev_err_o with dev_rvalid_o, return dev_rdata_o = 0, and not modify any register.
REQ-017 SHALL apply writes only to bytes whose dev_be_i bit is set; writes return dev_rdata_o = 0 and dev_err_o = 0.
REQ-018 SHALL return for a read the register value as it stood in the request cycle (before that cycle's update).
REQ-019 SHALL keep a prescale counter PC: when EN = 0, PC holds; when EN = 1 and PC == PRESCALE, PC <= 0 and a tick occurs; otherwise PC <= PC + 1.
REQ-020 SHALL increment 64-bit MTIME = {MTIME_HI, MTIME_LO} by 1 on each tick, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0 with no flag.
REQ-021 SHALL, when a write to MTIME_LO or MTIME_HI coincides with a tick, load the written bytes into that half, keep the other half unchanged, and drop the tick (no carry).
REQ-022 SHALL reset PC to 0 on any write to PRESCALE or CTRL.
REQ-023 SHALL register timer_irq_o: next value = EN && (MTIME >= MTIMECMP) using the post-update values of that cycle, unsigned 64-bit compare.
REQ-024 SHALL deassert timer_irq_o the cycle after a write raises MTIMECMP above MTIME or clears EN; MTIMECMP writes need no acknowledgement beyond the bus response.
REQ-025 SHALL treat a single 32-bit half write as atomic for that half only; software updates MTIMECMP as HI=all-ones, LO, HI to avoid spurious interrupts.

Reset
REQ-026 SHALL, while rst_ni = 0, force MTIME = 0, MTIMECMP = 0xFFFF_FFFF_FFFF_FFFF, CTRL = 0, PRESCALE = ResetPrescale, PC = 0, dev_rvalid_o = 0, dev_rdata_o = 0, dev_err_o = 0, timer_irq_o = 0.
REQ-027 SHALL discard any request in flight at reset assertion; no response is produced after reset release for it.
REQ-028 SHALL begin accepting requests on the first rising edge with rst_ni = 1.

Verification
REQ-029 SHALL cover: reset, read 0x08 and 0x0C -> rdata 0xFFFF_FFFF both, rvalid exactly one cycle after req, err = 0.
REQ-030 SHALL cover: PRESCALE=3, CTRL=1, wait 40 cycles -> MTIME_LO = 10 (+/-1 for write alignment), counting every 4th cycle.
REQ-031 SHALL cover: MTIME = 0xFFFF_FFFF_FFFF_FFFE, PRESCALE=0, EN=1 -> reads 0 at both halves two ticks later, no error.
REQ-032 SHALL cover: MTIMECMP = 20, PRESCALE=0, EN=1 from MTIME=0 -> timer_irq_o rises exactly one cycle after MTIME reaches 20; writing MTIMECMP_HI=1 -> irq low next cycle.
REQ-033 SHALL cover: read at offset 0x18 and write at 0x3FC -> dev_err_o = 1, rdata 0, registers unchanged; write 0x12 to 0x10 with be=4'b0010 -> CTRL unchanged (0).
REQ-034 SHALL cover: write MTIME_LO = 0x100 in a tick cycle -> MTIME_LO reads 0x100 (not 0x101), MTIME_HI unchanged; assert rst_ni mid-read -> no rvalid after release.
